// File: rtl/linear_pkg.sv
// Shared types and latency constants for the layer schedulers.
package linear_pkg;

    localparam int MEM_LATENCY  = 1;
    localparam int PIPE_LATENCY = 4;
    localparam int SCHED_DEPTH  = MEM_LATENCY + PIPE_LATENCY;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } sched_state_e;

endpackage

// File: rtl/valid_idx_pipe.sv
// Shift register carrying (valid, neuron index) alongside a datapath; frozen when shift_en is low.
module valid_idx_pipe #(
    parameter int DEPTH = 5,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_idx,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic             pending
);

    logic [DEPTH-1:0]            vld_pipe;
    logic [DEPTH-1:0][IDX_W-1:0] idx_pipe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            idx_pipe <= '0;
        end else if (shift_en) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                vld_pipe[i] <= vld_pipe[i-1];
                idx_pipe[i] <= idx_pipe[i-1];
            end
            vld_pipe[0] <= in_valid;
            idx_pipe[0] <= in_idx;
        end
    end

    assign out_valid = vld_pipe[DEPTH-1];
    assign out_idx   = idx_pipe[DEPTH-1];

    // Anything still in flight behind the output stage.
    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++)
            pending = pending | vld_pipe[i];
    end

endmodule

// File: rtl/linear_layer_scheduler.sv
// Sequences one linear-layer pass: per-neuron RAM reads, datapath enable, and result beat tracking.
module linear_layer_scheduler
    import linear_pkg::*;
#(
    parameter int MAX_OUTPUTS  = 256,
    parameter int IDX_W        = $clog2(MAX_OUTPUTS),
    parameter int MEM_LAT      = MEM_LATENCY,
    parameter int PIPE_LAT     = PIPE_LATENCY
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IDX_W:0]   num_outputs,
    output logic             busy,
    output logic             done,
    output logic             feat_load,
    output logic             mem_rd_en,
    output logic [IDX_W-1:0] mem_addr,
    output logic             dp_ce,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    input  logic             out_ready
);

    localparam int DEPTH = MEM_LAT + PIPE_LAT;

    sched_state_e   state, state_nxt;
    logic [IDX_W:0] issue_cnt;
    logic [IDX_W:0] num_q;
    logic           advance;
    logic           issue;
    logic           last_issue;
    logic           pending;

    // A beat held at the output without acceptance freezes the whole pipeline.
    assign advance    = !(out_valid && !out_ready);
    assign issue      = (state == RUN) && advance;
    assign last_issue = (issue_cnt == num_q - 1'b1);

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign feat_load = (state == LOAD);
    assign mem_rd_en = issue;
    assign mem_addr  = issue_cnt[IDX_W-1:0];
    assign dp_ce     = advance && ((state == RUN) || (state == DRAIN));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            issue_cnt <= '0;
            num_q     <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                num_q     <= num_outputs;
                issue_cnt <= '0;
            end else if (issue) begin
                issue_cnt <= issue_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    state_nxt = (num_q == '0) ? DONE : RUN;
            RUN:     if (issue && last_issue) state_nxt = DRAIN;
            DRAIN:   if (!pending && advance) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    valid_idx_pipe #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .shift_en  (dp_ce),
        .in_valid  (issue),
        .in_idx    (issue_cnt[IDX_W-1:0]),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .pending   (pending)
    );

endmodule

// File: tb/tb_linear_layer_scheduler.sv
// Directed bench for linear_layer_scheduler with a per-cycle reference model.
module tb_linear_layer_scheduler;

    localparam int IDX_W = 8;
    localparam int D     = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [IDX_W:0]   num_outputs;
    logic             busy, done, feat_load, mem_rd_en, dp_ce, out_valid;
    logic [IDX_W-1:0] mem_addr, out_idx;
    logic             out_ready;

    linear_layer_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_outputs (num_outputs),
        .busy        (busy),
        .done        (done),
        .feat_load   (feat_load),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .dp_ce       (dp_ce),
        .out_valid   (out_valid),
        .out_idx     (out_idx),
        .out_ready   (out_ready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model: phase 0 idle, 1 load, 2 active, 3 done; m_a counts advancing cycles in the active phase.
    int m_phase = 0;
    int m_n     = 0;
    int m_a     = 0;

    // Per-pass statistics
    int st_beats, st_done, st_busy, st_rd, st_valid, st_ce, st_last_idx;
    int st_feat_cyc, st_done_cyc, st_first_rd, st_first_vld;
    int st_stall, st_stall_idx, st_stall_rd, st_first_idx;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clr_stats();
        st_beats = 0; st_done = 0; st_busy = 0; st_rd = 0; st_valid = 0; st_ce = 0;
        st_last_idx = -1; st_feat_cyc = -1; st_done_cyc = -1; st_first_rd = -1;
        st_first_vld = -1; st_stall = 0; st_stall_idx = -1; st_stall_rd = 0; st_first_idx = -1;
    endtask

    task automatic tick();
        bit e_ov, e_adv, e_rd, e_ce;
        int e_oidx;
        @(negedge clk);
        if (rst) m_phase = 0;
        e_ov   = (m_phase == 2) && (m_a >= D) && (m_a - D < m_n);
        e_oidx = m_a - D;
        e_adv  = !(e_ov && !out_ready);
        e_rd   = (m_phase == 2) && (m_a < m_n) && e_adv;
        e_ce   = (m_phase == 2) && e_adv;
        chk("busy",      int'(busy),      int'(m_phase != 0));
        chk("feat_load", int'(feat_load), int'(m_phase == 1));
        chk("done",      int'(done),      int'(m_phase == 3));
        chk("out_valid", int'(out_valid), int'(e_ov));
        chk("mem_rd_en", int'(mem_rd_en), int'(e_rd));
        chk("dp_ce",     int'(dp_ce),     int'(e_ce));
        if (e_ov) chk("out_idx", int'(out_idx), e_oidx);
        if (e_rd) chk("mem_addr", int'(mem_addr), m_a % 256);
        // statistics from the DUT's own outputs
        if (busy) st_busy++;
        if (mem_rd_en) begin
            st_rd++;
            if (st_first_rd < 0) st_first_rd = cyc;
        end
        if (out_valid) begin
            st_valid++;
            if (st_first_vld < 0) st_first_vld = cyc;
            if (!out_ready) begin
                st_stall++;
                st_stall_idx = int'(out_idx);
                if (mem_rd_en) st_stall_rd++;
            end else begin
                st_beats++;
                if (st_first_idx < 0) st_first_idx = int'(out_idx);
                st_last_idx = int'(out_idx);
            end
        end
        if (dp_ce) st_ce++;
        if (feat_load) st_feat_cyc = cyc;
        if (done) begin
            st_done++;
            st_done_cyc = cyc;
        end
        // model next state
        if (rst) begin
            m_phase = 0;
        end else begin
            case (m_phase)
                0: if (start) begin m_phase = 1; m_n = int'(num_outputs); end
                1: begin m_phase = (m_n == 0) ? 3 : 2; m_a = 0; end
                2: if (e_adv) begin
                       if (e_ov && e_oidx == m_n - 1) m_phase = 3;
                       else m_a++;
                   end
                default: m_phase = 0;
            endcase
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Runs one pass; stall_at >= 0 holds out_ready low 3 cycles on that beat,
    // restart_at >= 0 re-pulses start once that many beats have been accepted.
    task automatic run_pass(input int n, input int stall_at, input int restart_at, output int start_cyc);
        int  stall_rem = 0;
        bit  stalled   = 0;
        bit  restarted = 0;
        int  budget;
        clr_stats();
        num_outputs = (IDX_W+1)'(n);
        start       = 1'b1;
        start_cyc   = cyc;
        tick();
        start  = 1'b0;
        budget = n + 60;
        while (st_done == 0 && budget > 0) begin
            if (!stalled && stall_at >= 0 && out_valid && int'(out_idx) == stall_at) begin
                stalled   = 1;
                stall_rem = 3;
            end
            if (stall_rem > 0) begin
                out_ready = 1'b0;
                stall_rem--;
            end else begin
                out_ready = 1'b1;
            end
            start = (!restarted && restart_at >= 0 && st_beats == restart_at);
            if (start) restarted = 1;
            tick();
            start = 1'b0;
            budget--;
        end
        if (budget == 0) chk("pass_timeout", 0, 1);
        out_ready = 1'b1;
        tick();
    endtask

    initial begin
        int sc;
        int budget;
        rst = 1'b1; start = 1'b0; num_outputs = '0; out_ready = 1'b1;
        clr_stats();
        tick();
        tick();
        chk("rst_mem_addr", int'(mem_addr), 0);
        chk("rst_out_idx",  int'(out_idx), 0);
        chk("rst_busy",     int'(busy), 0);
        rst = 1'b0;
        tick();

        // 1: four neurons, no back-pressure
        run_pass(4, -1, -1, sc);
        chk("t1_feat_lat",  st_feat_cyc - sc, 1);
        chk("t1_first_rd",  st_first_rd - sc, 2);
        chk("t1_first_vld", st_first_vld - st_first_rd, 5);
        chk("t1_done_lat",  st_done_cyc - sc, 11);
        chk("t1_beats",     st_beats, 4);
        chk("t1_last_idx",  st_last_idx, 3);

        // 2: empty pass
        run_pass(0, -1, -1, sc);
        chk("t2_busy_cyc", st_busy, 2);
        chk("t2_rd",       st_rd, 0);
        chk("t2_ce",       st_ce, 0);
        chk("t2_valid",    st_valid, 0);
        chk("t2_done_lat", st_done_cyc - sc, 2);

        // 3: back-pressure on beat 2
        run_pass(8, 2, -1, sc);
        chk("t3_beats",     st_beats, 8);
        chk("t3_stall_cyc", st_stall, 3);
        chk("t3_stall_idx", st_stall_idx, 2);
        chk("t3_stall_rd",  st_stall_rd, 0);
        chk("t3_done_lat",  st_done_cyc - sc, 1 + 8 + 5 + 1 + 3);

        // 4: full-size pass
        run_pass(256, -1, -1, sc);
        chk("t4_beats",    st_beats, 256);
        chk("t4_last_idx", st_last_idx, 255);
        chk("t4_done_cnt", st_done, 1);
        chk("t4_rd_cnt",   st_rd, 256);
        chk("t4_done_lat", st_done_cyc - sc, 1 + 256 + 5 + 1);

        // 5: abort mid-run after three beats
        clr_stats();
        num_outputs = 9'd16;
        start = 1'b1;
        tick();
        start  = 1'b0;
        budget = 40;
        while (st_beats < 3 && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) chk("t5_timeout", 0, 1);
        rst = 1'b1;
        #1;
        chk("t5_async_busy",  int'(busy), 0);
        chk("t5_async_valid", int'(out_valid), 0);
        chk("t5_async_rd",    int'(mem_rd_en), 0);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("t5_no_done", st_done, 0);
        run_pass(4, -1, -1, sc);
        chk("t5_first_idx", st_first_idx, 0);
        chk("t5_beats",     st_beats, 4);

        // 6: start re-pulsed while busy
        run_pass(6, -1, 2, sc);
        chk("t6_done_cnt", st_done, 1);
        chk("t6_beats",    st_beats, 6);
        chk("t6_done_lat", st_done_cyc - sc, 1 + 6 + 5 + 1);
        repeat (3) tick();
        chk("t6_idle", int'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
